// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC and IR, issues single-word reads to
// instruction memory, and raises a sticky fault on misaligned fetch or timeout.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    input  logic        fault_clr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_FAULT = 2'd2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]  state_reg;
    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic        ir_valid_reg;
    logic        mem_req_reg;
    logic [31:0] mem_addr_reg;
    logic        fault_reg;
    logic [7:0]  timer_reg;
    logic [31:0] pend_pc_reg;
    logic        pend_valid_reg;

    logic [31:0] fetch_addr;
    logic [7:0]  timer_inc;
    logic [31:0] pend_addr;
    logic        pend_any;

    always_comb begin
        fetch_addr = pc_load ? pc_next : pc_reg;
        timer_inc  = (timer_reg == 8'hFF) ? timer_reg : timer_reg + 8'd1;
        // A pc_load on the very cycle the fetch ends still counts as pending.
        pend_addr  = pc_load ? pc_next : pend_pc_reg;
        pend_any   = pc_load | pend_valid_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            ir_reg         <= NOP;
            ir_valid_reg   <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= 32'h0;
            fault_reg      <= 1'b0;
            timer_reg      <= 8'h0;
            pend_pc_reg    <= 32'h0;
            pend_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pc_load)
                        pc_reg <= pc_next;
                    if (fetch_start) begin
                        ir_valid_reg <= 1'b0;
                        if (fetch_addr[1:0] == 2'b00) begin
                            state_reg    <= ST_WAIT;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= fetch_addr;
                            timer_reg    <= 8'h0;
                        end else begin
                            state_reg <= ST_FAULT;
                            fault_reg <= 1'b1;
                        end
                    end else if (pc_load) begin
                        ir_valid_reg <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack || timer_inc >= TIMEOUT_CNT) begin
                        mem_req_reg    <= 1'b0;
                        pend_valid_reg <= 1'b0;
                        if (pend_any)
                            pc_reg <= pend_addr;
                        if (mem_ack) begin
                            ir_reg       <= mem_rdata;
                            ir_valid_reg <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end else begin
                            timer_reg <= timer_inc;
                            fault_reg <= 1'b1;
                            state_reg <= ST_FAULT;
                        end
                    end else begin
                        timer_reg <= timer_inc;
                        if (pc_load) begin
                            pend_pc_reg    <= pc_next;
                            pend_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (pc_load) begin
                        pc_reg       <= pc_next;
                        ir_valid_reg <= 1'b0;
                    end
                    if (fault_clr) begin
                        state_reg <= ST_IDLE;
                        fault_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign pc       = pc_reg;
    assign ir       = ir_reg;
    assign opcode   = ir_reg[6:0];
    assign ir_valid = ir_valid_reg;
    assign busy     = (state_reg == ST_WAIT);
    assign fault    = fault_reg;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles without mem_ack before fault (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fetch_start  input  1  one-cycle request from control unit to fetch the next instruction.
REQ-006 SHALL have port pc_load  input  1  load PC from pc_next.
REQ-007 SHALL have port pc_next  input  32  next PC from datapath.
REQ-008 SHALL have port fault_clr  input  1  clears sticky fault.
REQ-009 SHALL have port mem_req  output  1  instruction memory read request.
REQ-010 SHALL have port mem_addr  output  32  read address, word-aligned.
REQ-011 SHALL have port mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-012 SHALL have port mem_ack  input  1  memory completion, one cycle.
REQ-013 SHALL have port pc  output  32  current PC.
REQ-014 SHALL have port ir  output  32  instruction register.
REQ-015 SHALL have port opcode  output  7  ir[6:0], combinational, feeds control unit.
REQ-016 SHALL have port ir_valid  output  1  ir holds the instruction fetched from current pc.
REQ-017 SHALL have port busy  output  1  high in WAIT.
REQ-018 SHALL have port fault  output  1  sticky misalignment/timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, FAULT; busy=1 only in WAIT.
REQ-020 IDLE, fetch_start=1, fetch address aligned: next cycle state=WAIT, mem_req=1, mem_addr=fetch address, ir_valid=0, timer=0.
REQ-021 Fetch address SHALL be pc_next if pc_load=1 in same cycle (PC also updated), else pc.
REQ-022 IDLE, fetch_start=1, fetch address[1:0]!=0: no request; next cycle state=FAULT, fault=1, ir_valid=0, ir unchanged.
REQ-023 WAIT: mem_req and mem_addr SHALL stay stable until mem_ack sampled high.
REQ-024 WAIT, mem_ack=1: ir<=mem_rdata, ir_valid<=1, mem_req<=0, state<=IDLE; fetch latency = ack cycle + 1.
REQ-025 WAIT, mem_ack=0: timer increments; when timer reaches TIMEOUT, mem_req<=0, fault<=1, state<=FAULT.
REQ-026 mem_ack in IDLE or FAULT SHALL be ignored (no ir change).
REQ-027 fetch_start in WAIT or FAULT SHALL be ignored.
REQ-028 pc_load in IDLE or FAULT: pc<=pc_next next cycle.
REQ-029 pc_load in WAIT: pc_next captured into one-entry pending buffer; pc unchanged until fetch ends; applied to pc the cycle after ack or timeout; later pc_load in same WAIT overwrites buffer.
REQ-030 FAULT: held until fault_clr=1, then state<=IDLE, fault<=0; pending pc_load already applied.
REQ-031 fault_clr outside FAULT SHALL have no effect.
REQ-032 timer SHALL be 8 bits, saturating, reset on WAIT entry.

Reset
REQ-033 reset=0 SHALL asynchronously force: state=IDLE, pc=RESET_PC, ir=32'h0000_0013 (NOP), ir_valid=0, mem_req=0, mem_addr=0, busy=0, fault=0, timer=0, pending buffer empty.
REQ-034 Reset mid-WAIT SHALL drop mem_req immediately; a mem_ack arriving after release SHALL be ignored.

Verification
REQ-035 Reset, fetch_start, mem_ack after 3 cycles with rdata=32'h00500093 -> mem_addr=0 during WAIT, ir=32'h00500093, opcode=7'b0010011, ir_valid=1.
REQ-036 pc_load=1, pc_next=32'h40 with fetch_start same cycle -> mem_addr=32'h40, pc=32'h40.
REQ-037 pc_load pc_next=32'h80 during WAIT -> pc unchanged until ack, pc=32'h80 cycle after ack.
REQ-038 fetch_start with pc_next=32'h42 and pc_load -> no mem_req, fault=1; fault_clr -> IDLE, fault=0.
REQ-039 TIMEOUT=4, no mem_ack -> mem_req drops after 4 WAIT cycles, fault=1, ir unchanged.
REQ-040 reset asserted mid-WAIT then late mem_ack -> mem_req=0 immediately, ir=32'h00000013, ir_valid=0.
